// File: rtl/game_pkg.sv
// Shared encodings for the race-game flow controller: screens, key codes, winners, FSM states.
package game_pkg;

  localparam int SEC_W = 4;

  localparam logic [1:0] SCR_MENU      = 2'd0;
  localparam logic [1:0] SCR_COUNTDOWN = 2'd1;
  localparam logic [1:0] SCR_RACE      = 2'd2;
  localparam logic [1:0] SCR_FINISH    = 2'd3;

  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_ENTER = 3'd3;
  localparam logic [2:0] KEY_ESC   = 3'd4;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  typedef enum logic [2:0] {
    ST_MENU,
    ST_COUNTDOWN,
    ST_RACE,
    ST_PAUSE,
    ST_FINISH
  } state_e;

  // Pause keeps the race picture underneath its overlay.
  function automatic logic [1:0] screen_of(state_e s);
    case (s)
      ST_COUNTDOWN:     screen_of = SCR_COUNTDOWN;
      ST_RACE,
      ST_PAUSE:         screen_of = SCR_RACE;
      ST_FINISH:        screen_of = SCR_FINISH;
      default:          screen_of = SCR_MENU;
    endcase
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Seconds down-counter advanced by frame ticks; load has priority over enable.
// done_o is combinational on the tick that takes the count from 1 to 0; no backpressure.
module sec_timer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int SEC_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [SEC_W-1:0] load_sec_i,
  input  logic             en_i,
  output logic [SEC_W-1:0] sec_nxt_o,
  output logic             done_o
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

  logic [FW-1:0]    frame_q, frame_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             sec_wrap;

  assign sec_wrap = en_i && (frame_q == FRAME_LAST) && (sec_q != '0);

  always_comb begin
    frame_d = frame_q;
    sec_d   = sec_q;
    if (load_i) begin
      frame_d = '0;
      sec_d   = load_sec_i;
    end else if (en_i && (sec_q != '0)) begin
      if (sec_wrap) begin
        frame_d = '0;
        sec_d   = sec_q - SEC_W'(1);
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
      sec_q   <= '0;
    end else begin
      frame_q <= frame_d;
      sec_q   <= sec_d;
    end
  end

  assign sec_nxt_o = sec_d;
  assign done_o    = sec_wrap && (sec_q == SEC_W'(1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Screen scheduler for the race game: menu, countdown, race, pause, finish.
// Input edge to registered outputs in 2 cycles; no backpressure, every event is acted on at once.
module game_flow_ctrl #(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int COUNTDOWN_SEC   = 3,
  parameter int FINISH_HOLD_SEC = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic [2:0]  keyboard_in,
  input  logic        start_game_flag,
  input  logic [1:0]  race_finished,
  output logic [1:0]  screen_sel,
  output logic        race_enable,
  output logic        pause_overlay,
  output logic [1:0]  countdown_digit,
  output logic [15:0] race_frames,
  output logic [1:0]  winner,
  output logic        back_to_main_menu_flag
);
  import game_pkg::*;

  logic       vs_q, vs_prev_q, start_q, start_prev_q;
  logic [2:0] key_q, key_prev_q;
  logic       frame_tick, key_ev, start_ev, esc_ev, enter_ev;

  state_e      state_q, state_d;
  logic [15:0] race_frames_q, race_frames_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  screen_q, screen_d, digit_q, digit_d;
  logic        race_en_q, race_en_d, pause_q, pause_d, back_q, back_d;

  logic             tmr_load, tmr_en, tmr_done, key_exit, entering;
  logic [SEC_W-1:0] tmr_load_sec, sec_nxt;

  assign frame_tick = vs_q && !vs_prev_q;
  assign start_ev   = start_q && !start_prev_q;
  assign key_ev     = (key_q != key_prev_q) && (key_q != KEY_NONE);
  assign esc_ev     = key_ev && (key_q == KEY_ESC);
  assign enter_ev   = key_ev && (key_q == KEY_ENTER);

  // A key-driven exit swallows a same-cycle frame tick so the timer does not advance.
  assign key_exit = ((state_q == ST_COUNTDOWN) && esc_ev) ||
                    ((state_q == ST_FINISH) && enter_ev);
  assign tmr_en   = frame_tick && !key_exit &&
                    ((state_q == ST_COUNTDOWN) || (state_q == ST_FINISH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MENU:      if (start_ev) state_d = ST_COUNTDOWN;
      ST_COUNTDOWN: begin
        if (esc_ev)        state_d = ST_MENU;
        else if (tmr_done) state_d = ST_RACE;
      end
      ST_RACE: begin
        if (race_finished != 2'b00) state_d = ST_FINISH;
        else if (esc_ev)            state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (enter_ev)    state_d = ST_RACE;
        else if (esc_ev) state_d = ST_MENU;
      end
      ST_FINISH:    if (enter_ev || tmr_done) state_d = ST_MENU;
      default:      state_d = ST_MENU;
    endcase
  end

  assign entering     = (state_d != state_q);
  assign tmr_load     = entering && ((state_d == ST_COUNTDOWN) || (state_d == ST_FINISH));
  assign tmr_load_sec = (state_d == ST_COUNTDOWN) ? SEC_W'(COUNTDOWN_SEC)
                                                  : SEC_W'(FINISH_HOLD_SEC);

  sec_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .SEC_W         (SEC_W)
  ) u_sec_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_sec_i(tmr_load_sec),
    .en_i      (tmr_en),
    .sec_nxt_o (sec_nxt),
    .done_o    (tmr_done)
  );

  always_comb begin
    race_frames_d = race_frames_q;
    winner_d      = winner_q;
    if (entering && (state_d == ST_COUNTDOWN)) begin
      race_frames_d = '0;
      winner_d      = WIN_NONE;
    end else if ((state_q == ST_COUNTDOWN) && (state_d == ST_RACE)) begin
      race_frames_d = '0;
    end else if ((state_q == ST_RACE) && (state_d == ST_RACE) && frame_tick &&
                 (race_frames_q != 16'hFFFF)) begin
      race_frames_d = race_frames_q + 16'd1;
    end
    if (entering && (state_d == ST_FINISH)) winner_d = race_finished;

    screen_d  = screen_of(state_d);
    race_en_d = (state_d == ST_RACE);
    pause_d   = (state_d == ST_PAUSE);
    digit_d   = 2'd0;
    if (state_d == ST_COUNTDOWN) digit_d = (sec_nxt > SEC_W'(3)) ? 2'd3 : sec_nxt[1:0];
    back_d    = entering && (state_d == ST_MENU);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      start_q       <= 1'b0;
      start_prev_q  <= 1'b0;
      key_q         <= KEY_NONE;
      key_prev_q    <= KEY_NONE;
      state_q       <= ST_MENU;
      race_frames_q <= '0;
      winner_q      <= WIN_NONE;
      screen_q      <= SCR_MENU;
      race_en_q     <= 1'b0;
      pause_q       <= 1'b0;
      digit_q       <= 2'd0;
      back_q        <= 1'b0;
    end else begin
      vs_q          <= vsync_in;
      vs_prev_q     <= vs_q;
      start_q       <= start_game_flag;
      start_prev_q  <= start_q;
      key_q         <= keyboard_in;
      key_prev_q    <= key_q;
      state_q       <= state_d;
      race_frames_q <= race_frames_d;
      winner_q      <= winner_d;
      screen_q      <= screen_d;
      race_en_q     <= race_en_d;
      pause_q       <= pause_d;
      digit_q       <= digit_d;
      back_q        <= back_d;
    end
  end

  assign screen_sel             = screen_q;
  assign race_enable            = race_en_q;
  assign pause_overlay          = pause_q;
  assign countdown_digit        = digit_q;
  assign race_frames            = race_frames_q;
  assign winner                 = winner_q;
  assign back_to_main_menu_flag = back_q;

endmodule
